ibex_rvfi_trace_buffer: RTL and testbench

//  Sits downstream of the core's RVFI retirement port, in parallel with the text tracer.

---
 rtl/ibex_rvfi_trace_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_ibex_rvfi_trace_buffer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: captures one record per retired instruction
// into a circular FIFO and streams each record out as three 32-bit words.
// Records arriving while the FIFO is full are dropped and counted. The count
// rides in-band in the drop field of the next record that is stored.
module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth    = 16,
    parameter int unsigned DropCntW = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       flush_i,
    input  logic                       rvfi_valid,
    input  logic [31:0]                rvfi_pc_rdata,
    input  logic [31:0]                rvfi_insn,
    input  logic [4:0]                 rvfi_rd_addr,
    input  logic                       rvfi_trap,
    input  logic                       rvfi_halt,
    input  logic                       rvfi_intr,
    input  logic [1:0]                 rvfi_mode,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [31:0]                trace_data_o,
    output logic                       trace_last_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic                       overflow_o,
    output logic [31:0]                drop_total_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    localparam logic [PtrW-1:0]     PTR_ZERO  = {PtrW{1'b0}};
    localparam logic [PtrW-1:0]     PTR_ONE   = {{(PtrW-1){1'b0}}, 1'b1};
    localparam logic [LvlW-1:0]     LVL_ZERO  = {LvlW{1'b0}};
    localparam logic [LvlW-1:0]     LVL_ONE   = {{(LvlW-1){1'b0}}, 1'b1};
    localparam logic [LvlW-1:0]     LVL_FULL  = LvlW'(Depth);
    localparam logic [DropCntW-1:0] DROP_ZERO = {DropCntW{1'b0}};
    localparam logic [DropCntW-1:0] DROP_ONE  = {{(DropCntW-1){1'b0}}, 1'b1};
    localparam logic [DropCntW-1:0] DROP_MAX  = {DropCntW{1'b1}};
    localparam logic [31:0]         TOTAL_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } state_e;

    // Header word: fixed tag, destination, mode, flags and the drop count.
    function automatic logic [31:0] pack_w0(
        input logic [4:0]          rd,
        input logic [1:0]          mode,
        input logic                halt,
        input logic                intr,
        input logic                trap,
        input logic [DropCntW-1:0] drop
    );
        return {4'hA, rd, mode, halt, intr, trap, 18'(drop)};
    endfunction

    // Saturating increment for the per-record drop count.
    function automatic logic [DropCntW-1:0] drop_inc(input logic [DropCntW-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_ONE;
    endfunction

    // Saturating increment for the lifetime drop total.
    function automatic logic [31:0] total_inc(input logic [31:0] v);
        return (v == TOTAL_MAX) ? v : v + 32'd1;
    endfunction

    state_e                state_r;
    state_e                state_s;
    logic [PtrW-1:0]       wptr_r;
    logic [PtrW-1:0]       rptr_r;
    logic [LvlW-1:0]       level_r;
    logic [DropCntW-1:0]   drop_pend_r;
    logic                  overflow_r;
    logic [31:0]           drop_total_r;
    logic [31:0]           mem_w0_r [Depth];
    logic [31:0]           mem_w1_r [Depth];
    logic [31:0]           mem_w2_r [Depth];

    logic                  capture_s;
    logic                  full_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  valid_s;
    logic                  hs_s;
    logic                  pop_s;
    logic [31:0]           data_s;

    // Capture / drop / pop qualification; fullness is taken at the start of the cycle.
    always_comb begin
        capture_s = rvfi_valid & enable_i & ~flush_i;
        full_s    = (level_r == LVL_FULL);
        push_s    = capture_s & ~full_s;
        drop_s    = capture_s & full_s;
        valid_s   = (state_r != ST_IDLE);
        hs_s      = valid_s & trace_ready_i;
        pop_s     = hs_s & (state_r == ST_W2) & ~flush_i;
    end

    // Serializer next state: walk W0..W2 per handshake, flush abandons the record.
    always_comb begin
        state_s = state_r;
        if (flush_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = (level_r != LVL_ZERO) ? ST_W0 : ST_IDLE;
                ST_W0:   state_s = hs_s ? ST_W1 : ST_W0;
                ST_W1:   state_s = hs_s ? ST_W2 : ST_W1;
                ST_W2: begin
                    if (hs_s) begin
                        state_s = (level_r > LVL_ONE) ? ST_W0 : ST_IDLE;
                    end else begin
                        state_s = ST_W2;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Head-entry word selected by the serializer state; quiet zero when idle.
    always_comb begin
        data_s = 32'h0000_0000;
        case (state_r)
            ST_W0:   data_s = mem_w0_r[rptr_r];
            ST_W1:   data_s = mem_w1_r[rptr_r];
            ST_W2:   data_s = mem_w2_r[rptr_r];
            default: data_s = 32'h0000_0000;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_r  <= PTR_ZERO;
            rptr_r  <= PTR_ZERO;
            level_r <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Drop accounting: pending count rides on the next stored record, total survives flush.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_pend_r  <= DROP_ZERO;
            overflow_r   <= 1'b0;
            drop_total_r <= 32'h0000_0000;
        end else if (flush_i) begin
            drop_pend_r  <= DROP_ZERO;
            overflow_r   <= 1'b0;
        end else if (drop_s) begin
            drop_pend_r  <= drop_inc(drop_pend_r);
            overflow_r   <= 1'b1;
            drop_total_r <= total_inc(drop_total_r);
        end else if (push_s) begin
            drop_pend_r  <= DROP_ZERO;
        end
    end

    // Record storage; entries are only read once the occupancy says they are valid.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_w0_r[wptr_r] <= pack_w0(rvfi_rd_addr, rvfi_mode, rvfi_halt,
                                        rvfi_intr, rvfi_trap, drop_pend_r);
            mem_w1_r[wptr_r] <= rvfi_pc_rdata;
            mem_w2_r[wptr_r] <= rvfi_insn;
        end
    end

    assign trace_valid_o = valid_s;
    assign trace_data_o  = data_s;
    assign trace_last_o  = (state_r == ST_W2);
    assign level_o       = level_r;
    assign overflow_o    = overflow_r;
    assign drop_total_o  = drop_total_r;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Self-checking bench for ibex_rvfi_trace_buffer: table-driven single-record
// vectors, hand-written corner sequences and a randomized run, all checked
// against a queue-of-records reference model.
module tb_ibex_rvfi_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic        flush_i;
    logic        rvfi_valid;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_insn;
    logic [4:0]  rvfi_rd_addr;
    logic        rvfi_trap;
    logic        rvfi_halt;
    logic        rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic [4:0]  level_o;
    logic        overflow_o;
    logic [31:0] drop_total_o;

    always #5 clk_i = ~clk_i;

    ibex_rvfi_trace_buffer #(.Depth(DEPTH), .DropCntW(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .flush_i       (flush_i),
        .rvfi_valid    (rvfi_valid),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .rvfi_insn     (rvfi_insn),
        .rvfi_rd_addr  (rvfi_rd_addr),
        .rvfi_trap     (rvfi_trap),
        .rvfi_halt     (rvfi_halt),
        .rvfi_intr     (rvfi_intr),
        .rvfi_mode     (rvfi_mode),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_data_o  (trace_data_o),
        .trace_last_o  (trace_last_o),
        .level_o       (level_o),
        .overflow_o    (overflow_o),
        .drop_total_o  (drop_total_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [1:0]  mode;
        logic        halt;
        logic        intr;
        logic        trap;
        int unsigned drop;
    } rec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [1:0]  mode;
        logic        halt;
        logic        intr;
        logic        trap;
        logic [31:0] exp_w0;
    } vec_t;

    // Reference model state
    rec_t        q[$];
    int          idx;
    int unsigned m_pend;
    logic [31:0] m_total;
    logic        m_ovf;

    int          checks;
    int          failures;
    int          words_seen;
    logic [31:0] last_w0;
    logic        watch;
    logic [31:0] post_w;
    logic        post_last;

    // Sampled outputs (negedge of the most recent step)
    logic        s_valid, s_last, s_ovf;
    logic [31:0] s_data, s_total;
    logic [4:0]  s_level;
    logic        p_hold, p_last;
    logic [31:0] p_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input rec_t r, input int i);
        logic [31:0] w;
        if (i == 1) return r.pc;
        if (i == 2) return r.insn;
        w = 32'hA000_0000;
        w = w + (32'(r.rd) * 32'd8388608) + (32'(r.mode) * 32'd2097152)
              + (32'(r.halt) * 32'd1048576) + (32'(r.intr) * 32'd524288)
              + (32'(r.trap) * 32'd262144) + (r.drop % 32'd262144);
        return w;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.pc   = $urandom;
        r.insn = $urandom;
        r.rd   = 5'($urandom);
        r.mode = 2'($urandom);
        r.halt = 1'($urandom);
        r.intr = 1'($urandom);
        r.trap = 1'($urandom);
        r.drop = 0;
        return r;
    endfunction

    task automatic drive(input rec_t r, input logic v);
        rvfi_pc_rdata = r.pc;
        rvfi_insn     = r.insn;
        rvfi_rd_addr  = r.rd;
        rvfi_mode     = r.mode;
        rvfi_halt     = r.halt;
        rvfi_intr     = r.intr;
        rvfi_trap     = r.trap;
        rvfi_valid    = v;
    endtask

    // One clock: sample/check at negedge, advance the model, then move past the posedge.
    task automatic step();
        logic hs;
        logic full;
        rec_t r;
        @(negedge clk_i);
        s_valid = trace_valid_o;
        s_data  = trace_data_o;
        s_last  = trace_last_o;
        s_level = level_o;
        s_ovf   = overflow_o;
        s_total = drop_total_o;
        chk("level", level_o, q.size());
        chk("overflow", overflow_o, m_ovf);
        chk("drop_total", drop_total_o, m_total);
        if (p_hold) begin
            chk("hold_valid", trace_valid_o, 1);
            chk("hold_data", trace_data_o, p_data);
            chk("hold_last", trace_last_o, p_last);
        end
        hs = trace_valid_o & trace_ready_i;
        if (hs) begin
            words_seen++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL word_without_record actual=%h required=none", trace_data_o);
            end else begin
                chk("word", trace_data_o, exp_word(q[0], idx));
                chk("last", trace_last_o, (idx == 2));
                if (idx == 0) last_w0 = trace_data_o;
            end
            if (watch) begin
                post_w    = trace_data_o;
                post_last = trace_last_o;
                watch     = 1'b0;
            end
        end
        p_hold = trace_valid_o & ~trace_ready_i & ~flush_i;
        p_data = trace_data_o;
        p_last = trace_last_o;
        if (flush_i) begin
            q.delete();
            idx    = 0;
            m_pend = 0;
            m_ovf  = 1'b0;
        end else begin
            full = (q.size() == DEPTH);
            if (hs && q.size() > 0) begin
                idx++;
                if (idx == 3) begin
                    void'(q.pop_front());
                    idx = 0;
                end
            end
            if (rvfi_valid && enable_i) begin
                if (full) begin
                    if (m_pend < 65535) m_pend++;
                    if (m_total != 32'hFFFF_FFFF) m_total = m_total + 32'd1;
                    m_ovf = 1'b1;
                end else begin
                    r.pc = rvfi_pc_rdata;  r.insn = rvfi_insn;  r.rd = rvfi_rd_addr;
                    r.mode = rvfi_mode;    r.halt = rvfi_halt;  r.intr = rvfi_intr;
                    r.trap = rvfi_trap;    r.drop = m_pend;
                    q.push_back(r);
                    m_pend = 0;
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        enable_i = 1'b1;
        flush_i = 1'b0;
        rvfi_valid = 1'b0;
        trace_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", trace_valid_o, 0);
        chk("rst_data", trace_data_o, 0);
        chk("rst_last", trace_last_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_drop_total", drop_total_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        q.delete();
        idx = 0; m_pend = 0; m_total = 32'h0; m_ovf = 1'b0; p_hold = 1'b0;
    endtask

    task automatic drain(input string nm);
        trace_ready_i = 1'b1;
        rvfi_valid    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0 && !trace_valid_o) break;
            step();
        end
        chk({nm, "_drain_level"}, level_o, 0);
        chk({nm, "_drain_valid"}, trace_valid_o, 0);
    endtask

    vec_t vecs[4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r;
        int   w_start;
        int   captured;
        checks = 0; failures = 0; words_seen = 0; watch = 1'b0;
        post_w = 32'h0; post_last = 1'b0; last_w0 = 32'h0;
        r = rand_rec();
        drive(r, 1'b0);

        vecs[0] = '{32'h0000_0100, 32'h0013_0313, 5'd6,  2'd3, 1'b0, 1'b0, 1'b0, 32'hA360_0000};
        vecs[1] = '{32'h8000_0004, 32'hDEAD_BEEF, 5'd31, 2'd0, 1'b1, 1'b0, 1'b1, 32'hAF94_0000};
        vecs[2] = '{32'h1234_5678, 32'h0000_0073, 5'd0,  2'd1, 1'b0, 1'b1, 1'b0, 32'hA028_0000};
        vecs[3] = '{32'hFFFF_FFFC, 32'h3020_0073, 5'd1,  2'd2, 1'b1, 1'b1, 1'b1, 32'hA0DC_0000};

        do_reset();

        // T1: single records, exact latency and word sequence
        foreach (vecs[i]) begin
            r.pc = vecs[i].pc; r.insn = vecs[i].insn; r.rd = vecs[i].rd;
            r.mode = vecs[i].mode; r.halt = vecs[i].halt; r.intr = vecs[i].intr;
            r.trap = vecs[i].trap; r.drop = 0;
            trace_ready_i = 1'b1;
            drive(r, 1'b1);
            step();
            rvfi_valid = 1'b0;
            step();
            chk("t1_n1_valid", s_valid, 0);
            step();
            chk("t1_w0_valid", s_valid, 1);
            chk("t1_w0_data", s_data, vecs[i].exp_w0);
            chk("t1_w0_last", s_last, 0);
            step();
            chk("t1_w1_data", s_data, vecs[i].pc);
            chk("t1_w1_last", s_last, 0);
            step();
            chk("t1_w2_data", s_data, vecs[i].insn);
            chk("t1_w2_last", s_last, 1);
            step();
            chk("t1_after_valid", s_valid, 0);
        end

        // T2: two-record burst under toggling ready
        w_start = words_seen;
        trace_ready_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i < 2) drive(rand_rec(), 1'b1);
            else rvfi_valid = 1'b0;
            step();
            trace_ready_i = ~trace_ready_i;
        end
        chk("t2_words", words_seen - w_start, 6);
        drain("t2");

        // T3: overflow with ready held low
        trace_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(rand_rec(), 1'b1);
            step();
        end
        rvfi_valid = 1'b0;
        step();
        chk("t3_level", s_level, 16);
        chk("t3_overflow", s_ovf, 1);
        chk("t3_drop_total", s_total, 4);
        drain("t3a");
        trace_ready_i = 1'b1;
        drive(rand_rec(), 1'b1);
        step();
        drain("t3b");
        chk("t3_drop_field", last_w0 & 32'h0003_FFFF, 4);

        // T4: full FIFO, W2 pop and capture in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(rand_rec(), 1'b1);
            step();
        end
        rvfi_valid = 1'b0;
        step();
        trace_ready_i = 1'b1;
        step();
        step();
        drive(rand_rec(), 1'b1);
        step();
        rvfi_valid = 1'b0;
        trace_ready_i = 1'b0;
        step();
        chk("t4_level", s_level, 15);
        chk("t4_drop_total", s_total, 1);
        chk("t4_overflow", s_ovf, 1);
        drain("t4");

        // T6: flush while in W1 with 3 entries buffered
        trace_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(rand_rec(), 1'b1);
            step();
        end
        rvfi_valid = 1'b0;
        step();
        trace_ready_i = 1'b1;
        step();
        trace_ready_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        chk("t6_valid", s_valid, 0);
        chk("t6_level", s_level, 0);
        chk("t6_overflow", s_ovf, 0);
        chk("t6_drop_total", s_total, 1);
        watch = 1'b1;
        trace_ready_i = 1'b1;
        drive(rand_rec(), 1'b1);
        step();
        drain("t6");
        chk("t6_next_hdr", post_w >> 28, 32'hA);
        chk("t6_next_last", post_last, 0);

        // T7: capture disabled
        do_reset();
        enable_i = 1'b0;
        trace_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(rand_rec(), 1'b1);
            step();
        end
        rvfi_valid = 1'b0;
        step();
        chk("t7_level", s_level, 0);
        chk("t7_drop_total", s_total, 0);
        chk("t7_valid", s_valid, 0);
        enable_i = 1'b1;

        // T5: 40 random records with random ready, wrapping the pointers
        w_start  = words_seen;
        captured = 0;
        for (int i = 0; i < 3000 && captured < 40; i++) begin
            trace_ready_i = 1'($urandom_range(0, 1));
            if (q.size() < DEPTH && $urandom_range(0, 3) == 0) begin
                drive(rand_rec(), 1'b1);
                captured++;
            end else begin
                rvfi_valid = 1'b0;
            end
            step();
        end
        rvfi_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (q.size() == 0 && !trace_valid_o) break;
            trace_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        drain("t5");
        chk("t5_captured", captured, 40);
        chk("t5_words", words_seen - w_start, 120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
